// File: rtl/seq_mult_8x8_if.sv
// Operand/result bundle for the sequential multiplier.
// The master side issues start with its operands; the slave side computes and reports.
interface seq_mult_8x8_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    // Requester: drives the operation request, observes status and result
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    // Multiplier: consumes the request, produces status and result
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_mult_8x8.sv
// Unsigned N x N shift-add multiplier, one partial product per clock.
// IDLE accepts a request, RUN performs N iterations, DONE presents the
// freshly loaded product for a single cycle before returning to IDLE.
module seq_mult_8x8 #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult_8x8_if.slave bus
);
    // Counter must hold 0..N-1; one spare bit keeps N=power-of-two simple.
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [N-1:0]     mcand_q,   mcand_d;
    logic [N-1:0]     mplier_q,  mplier_d;
    logic [2*N-1:0]   acc_q,     acc_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    // Multiplicand aligned to the current iteration's bit weight
    logic [2*N-1:0]   addend;

    // State and datapath registers; reset clears everything including the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state and datapath update; everything holds unless the state acts on it
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        addend    = {{N{1'b0}}, mcand_q} << cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Accumulator is exactly 2N bits: a full product never overflows it
                if (mplier_q[0]) begin
                    acc_d = acc_q + addend;
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Zero operands still walk all N iterations
                if (cnt_q == CW'(N - 1)) begin
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule
